gbt_req_framer: RTL and testbench

Transmit-side framer for the GBT downlink. It takes 66-bit register requests (wr_en, wr_valid, address, data) and serialises them into the 7-word, 16-bit-per-BX frame format that `link_gbt_rx` parses. TTC bits are inserted into the top nibble of every word. The block sits in the 40 MHz TTC domain, directly upstream of the elink serialiser. Frames are emitted back to back so the receiver stays frame-locked.

---
 rtl/gbt_req_framer_pkg.sv | 43 ++++
 rtl/gbt_req_fifo.sv | 54 +++++
 rtl/gbt_req_framer.sv | 86 ++++++++
 tb/tb_gbt_req_framer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gbt_req_framer_pkg.sv
// Shared types and constants for the GBT downlink request framer.
// Frame layout helper lives here so framer and any future receiver model agree.
package gbt_req_framer_pkg;

  localparam int FRAME_LEN = 7;
  localparam int REQ_W     = 65;

  typedef logic [2:0] slot_t;
  localparam slot_t LAST_SLOT = slot_t'(FRAME_LEN - 1);

  // TTC nibble occupies gbt_dout[15:12] in this bit order.
  typedef struct packed {
    logic l1a;
    logic calpulse;
    logic resync;
    logic bc0;
  } ttc_t;

  typedef struct packed {
    logic        wr_valid;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  localparam req_t IDLE_FRAME = '0;

  // Low 12 bits of payload words 0..5; word 6 is handled by the framer.
  function automatic logic [11:0] frame_field(req_t f, slot_t s);
    logic [11:0] r;
    case (s)
      3'd0:    r = {f.wr_valid, f.wr_en, 2'b00, f.addr[31:24]};
      3'd1:    r = f.addr[23:12];
      3'd2:    r = f.addr[11:0];
      3'd3:    r = {4'h0, f.data[31:24]};
      3'd4:    r = f.data[23:12];
      3'd5:    r = f.data[11:0];
      default: r = 12'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gbt_req_fifo.sv
// Request buffer for the framer: synchronous FIFO with a registered head word.
// No bypass: an entry written on an edge becomes visible as head only after it.
module gbt_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The incoming word becomes head when it lands on the next read slot.
      if (do_push && (wr_ptr == rd_next)) head <= push_data;
      else                                head <= mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gbt_req_framer.sv
// GBT downlink framer: serialises buffered register requests into 7-word frames.
// Optional w6 checksum enabled by defining GBT_REQ_FRAMER_CHECKSUM_EN.
module gbt_req_framer
  import gbt_req_framer_pkg::*;
#(
  parameter logic [11:0] FRAME_END  = 12'hABC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        ttc_clk_40_i,
  input  logic        reset_n_i,
  input  logic [3:0]  ttc_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_en_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic [15:0] gbt_dout_o,
  output logic        frame_start_o,
  output logic        sent_o
);

  slot_t             slot_q, slot_d;
  req_t              frame_q, frame_d;
  logic [REQ_W-1:0]  fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [11:0]       csum, low_d;
  ttc_t              ttc;

  assign ttc         = ttc_i;
  assign req_ready_o = ~fifo_full;

  gbt_req_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(REQ_W)
  ) u_fifo (
    .clk       (ttc_clk_40_i),
    .rst_n     (reset_n_i),
    .push      (req_valid_i),
    .push_data ({req_wr_en_i, req_addr_i, req_data_i}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    frame_d  = frame_q;
    fifo_pop = 1'b0;
    // Frame register reloads only on the wrap edge and holds for all 7 words.
    if (slot_q == LAST_SLOT) begin
      if (!fifo_empty) begin
        frame_d  = req_t'({1'b1, fifo_head});
        fifo_pop = 1'b1;
      end else begin
        frame_d  = IDLE_FRAME;
      end
    end
    csum = FRAME_END;
`ifdef GBT_REQ_FRAMER_CHECKSUM_EN
    for (int i = 0; i < FRAME_LEN - 1; i++) begin
      csum = csum ^ frame_field(frame_d, slot_t'(i));
    end
`else
    csum = FRAME_END;
`endif
    low_d = (slot_d == LAST_SLOT) ? csum : frame_field(frame_d, slot_d);
  end

  always_ff @(posedge ttc_clk_40_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot_q        <= LAST_SLOT;
      frame_q       <= IDLE_FRAME;
      gbt_dout_o    <= '0;
      frame_start_o <= 1'b0;
      sent_o        <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      frame_q       <= frame_d;
      gbt_dout_o    <= {ttc, low_d};
      frame_start_o <= (slot_d == '0);
      sent_o        <= (slot_d == LAST_SLOT) && frame_d.wr_valid;
    end
  end

endmodule

// File: tb/tb_gbt_req_framer.sv
// Bench for gbt_req_framer: directed scenarios plus random traffic against a
// cycle-level frame model built from the word layout table.
module tb_gbt_req_framer;

  localparam int          DEPTH = 4;
  localparam logic [11:0] FEND  = 12'hABC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ttc;
  logic        req_valid, req_ready, req_wr_en;
  logic [31:0] req_addr, req_data;
  logic [15:0] dout;
  logic        frame_start, sent;

  gbt_req_framer #(.FRAME_END(FEND), .FIFO_DEPTH(DEPTH)) dut (
    .ttc_clk_40_i (clk),
    .reset_n_i    (rst_n),
    .ttc_i        (ttc),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_wr_en_i  (req_wr_en),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .gbt_dout_o   (dout),
    .frame_start_o(frame_start),
    .sent_o       (sent)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_slot;
  logic [64:0] m_q[$];
  logic        m_valid;
  logic [11:0] m_w[7];
  logic [15:0] exp_q[$];
  logic [15:0] lit_req[7];
  int          lit_mode = 0;
  bit          accepted;
  int          cyc = 0;
  int          sent_cnt = 0;
  int          prev_sent = -1;
  bit          track_gap = 0;

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(logic v, logic we, logic [31:0] a, logic [31:0] d);
    req_valid = v;
    req_wr_en = we;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic model_reset();
    m_slot  = 6;
    m_valid = 1'b0;
    m_q.delete();
    exp_q.delete();
  endtask

  task automatic model_load();
    logic [64:0] e;
    logic [31:0] a, d;
    logic [11:0] x;
    if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_valid = 1'b1;
    end else begin
      e = '0;
      m_valid = 1'b0;
    end
    a = e[63:32];
    d = e[31:0];
    m_w[0] = 12'((32'(m_valid) << 11) | (32'(e[64]) << 10) | (a >> 24));
    m_w[1] = 12'((a >> 12) & 32'hFFF);
    m_w[2] = 12'(a & 32'hFFF);
    m_w[3] = 12'(d >> 24);
    m_w[4] = 12'((d >> 12) & 32'hFFF);
    m_w[5] = 12'(d & 32'hFFF);
    x = FEND;
`ifdef GBT_REQ_FRAMER_CHECKSUM_EN
    for (int i = 0; i < 6; i++) x = x ^ m_w[i];
`endif
    m_w[6] = x;
  endtask

  // One clock: advance the model with the inputs held across the edge, then compare.
  task automatic step();
    bit pre_ready;
    pre_ready = (m_q.size() < DEPTH);
    accepted  = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (m_slot == 6) begin
      m_slot = 0;
      model_load();
    end else begin
      m_slot++;
    end
    if (req_valid && pre_ready) begin
      m_q.push_back({req_wr_en, req_addr, req_data});
      accepted = 1'b1;
    end
    exp_q.push_back({ttc, m_w[m_slot]});
    check("dout", dout, exp_q.pop_front());
    check("frame_start", 16'(frame_start), 16'(m_slot == 0));
    check("sent", 16'(sent), 16'(m_slot == 6 && m_valid));
    check("ready", 16'(req_ready), 16'(m_q.size() < DEPTH));
    if (lit_mode == 1) check("idle_lit", dout, (m_slot == 6) ? 16'h0ABC : 16'h0000);
    if (lit_mode == 2 && m_valid) check("req_lit", dout, lit_req[m_slot]);
    if (sent === 1'b1) begin
      sent_cnt++;
      if (track_gap && prev_sent >= 0) check("sent_gap", 16'(cyc - prev_sent), 16'd7);
      prev_sent = cyc;
    end
  endtask

  task automatic wait_slot(int s);
    for (int i = 0; i < 7 && m_slot != s; i++) step();
  endtask

  initial begin
    int n_acc;
    int hits;
    lit_req[0] = 16'hFC40; lit_req[1] = 16'hF000; lit_req[2] = 16'hF000;
    lit_req[3] = 16'hF012; lit_req[4] = 16'hF345; lit_req[5] = 16'hF678;
`ifdef GBT_REQ_FRAMER_CHECKSUM_EN
    lit_req[6] = 16'hF3D3;
`else
    lit_req[6] = 16'hFABC;
`endif
    rst_n = 1'b0;
    ttc   = 4'h0;
    set_req(1'b0, 1'b0, '0, '0);
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", dout, 16'h0000);
    check("rst_start", 16'(frame_start), 16'd0);
    check("rst_sent", 16'(sent), 16'd0);
    check("rst_ready", 16'(req_ready), 16'd1);
    rst_n = 1'b1;

    // Idle frames
    lit_mode = 1;
    repeat (21) step();
    lit_mode = 0;

    // Single write request with all TTC bits set
    ttc = 4'hF;
    wait_slot(2);
    set_req(1'b1, 1'b1, 32'h4000_0000, 32'h1234_5678);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    lit_mode = 2;
    sent_cnt = 0;
    repeat (16) step();
    lit_mode = 0;
    check("single_sent_cnt", 16'(sent_cnt), 16'd1);
    ttc = 4'h0;

    // Five back-to-back requests into a depth-4 buffer
    wait_slot(0);
    sent_cnt  = 0;
    prev_sent = -1;
    track_gap = 1;
    n_acc     = 0;
    for (int i = 0; i < 60 && n_acc < 5; i++) begin
      set_req(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      step();
      if (accepted) begin
        n_acc++;
        if (n_acc == 4) check("full_after4", 16'(req_ready), 16'd0);
      end
    end
    check("b2b_accepted", 16'(n_acc), 16'd5);
    set_req(1'b0, 1'b0, '0, '0);
    repeat (40) step();
    check("b2b_sent_cnt", 16'(sent_cnt), 16'd5);
    track_gap = 0;

    // Push on the wrap edge with an empty buffer
    wait_slot(6);
    set_req(1'b1, 1'b0, 32'hA5A5_0001, 32'h0BAD_CAFE);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    check("edge_idle_w0", 16'(dout[11:0]), 16'h000);
    repeat (7) step();
    check("edge_next_w0", 16'(dout[11]), 16'd1);

    // Single-cycle bc0 mid-frame
    repeat (7) step();
    wait_slot(2);
    hits = 0;
    ttc = 4'h1;
    step();
    hits += int'(dout[12]);
    ttc = 4'h0;
    repeat (10) begin
      step();
      hits += int'(dout[12]);
    end
    check("bc0_hits", 16'(hits), 16'd1);

    // Asynchronous reset during w3 with two requests buffered
    wait_slot(0);
    set_req(1'b1, 1'b1, 32'h0000_1111, 32'h2222_3333);
    step();
    set_req(1'b1, 1'b0, 32'h4444_5555, 32'h6666_7777);
    step();
    set_req(1'b0, 1'b0, '0, '0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 16'h0000);
    check("arst_start", 16'(frame_start), 16'd0);
    check("arst_ready", 16'(req_ready), 16'd1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lit_mode = 1;
    sent_cnt = 0;
    repeat (14) step();
    lit_mode = 0;
    check("arst_no_sent", 16'(sent_cnt), 16'd0);

    // Random traffic
    repeat (1500) begin
      ttc = 4'($urandom_range(0, 15));
      set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
